// File: rtl/ff_share_arbiter.sv
// ff_share_arbiter: round-robin owner of a single shared W-bit register among N requesters.
// Latency: request seen in IDLE is granted and its lane loaded into q at the same edge;
// ownership is held up to HOLD_CYC cycles, then at least one IDLE cycle precedes the next grant.
// Backpressure: non-owner requests are not queued; they must stay high until the arbiter returns to IDLE.
//
// Ports:
//   clk   - clock, all state on rising edge
//   rst   - synchronous active-low reset
//   req   - per-requester level request
//   wdata - N lanes of W bits, lane i at wdata[i*W +: W]
//   gnt   - registered one-hot grant (zero when no owner)
//   owner - index of current or most recent owner
//   busy  - high while an owner holds the register
//   q     - shared register contents
module ff_share_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int HOLD_CYC = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic [W-1:0]         q
);

  localparam int OW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic          win_vld;
  logic [OW-1:0] win_idx;

  // Round-robin scan starting one past the last winner. Iterating i=1..N
  // ends on ptr itself, so the last winner is considered only when nobody
  // else is asking.
  always_comb begin
    int            idx;
    logic [OW-1:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      idx  = (int'(ptr_q) + i) % N;
      cand = OW'(idx);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // State register and datapath registers; reset overrides every update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(N - 1);
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d        = HOLD;
          q_d            = wdata[win_idx*W +: W];
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
          ptr_d          = win_idx;
          cnt_d          = 4'(HOLD_CYC - 1);
          busy_d         = 1'b1;
        end
      end
      HOLD: begin
        // Release and timeout share one exit; the edge that exits never
        // grants, which guarantees the idle gap between owners.
        if (!req[owner_q] || (cnt_q == 4'd0)) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    gnt   = gnt_q;
    owner = owner_q;
    busy  = busy_q;
    q     = q_q;
  end

endmodule

// File: doc/ff_share_arbiter.md
# ff_share_arbiter

Round-robin arbiter and sequencer that shares a single W-bit flip-flop register between N requesters. Each requester raises `req` with its data on `wdata`. The arbiter picks one winner, loads that winner's data into the shared register `q`, and holds ownership for a bounded number of cycles or until the owner drops its request. The block sits between the requester logic and the shared `flipflop` storage and is the only writer of that storage.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `W`, default 8: width of the shared register and of each data lane.
- `HOLD_CYC`, default 3: maximum cycles a winner owns the register, 1..15.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-low reset (0 = reset, sampled on the `clk` rising edge).
- `req`  in  N: request per requester, level-sensitive; held high while the requester wants ownership.
- `wdata`  in  N*W: data lanes; lane i is `wdata[i*W +: W]`.
- `gnt`  out  N: one-hot grant, registered; all-zero when no owner.
- `owner`  out  clog2(N): index of the current or last owner, registered.
- `busy`  out  1: high while in HOLD.
- `q`  out  W: shared register contents.

## Operation
- States: IDLE and HOLD. Internal registers: `ptr` (last winner), `cnt` (4-bit hold counter).
- Reset (`rst`=0 at an edge): state=IDLE, `q`=0, `gnt`=0, `owner`=0, `busy`=0, `cnt`=0, `ptr`=N-1 (so requester 0 has first priority).
- Reset wins over every other event, including mid-HOLD. No partial update of `q` is allowed in the reset cycle.
- IDLE, `req`==0: all state holds and `q` retains its value.
- IDLE, `req`!=0: the winner is the first index with `req` set, scanning ptr+1, ptr+2, … modulo N. At that edge:
  - `q` <= lane of the winner; `gnt` <= onehot(winner); `owner` <= winner; `ptr` <= winner;
  - `cnt` <= HOLD_CYC-1; `busy` <= 1; state <= HOLD.
- HOLD: `q` is frozen and all `wdata` lanes are ignored. Requests from non-owners are ignored, not queued; they must stay high to be seen.
- HOLD exit (state <= IDLE, `gnt` <= 0, `busy` <= 0) happens at the first edge where either:
  - `req[owner]`==0 (early release), or
  - `cnt`==0 (timeout).
  
  Otherwise `cnt` <= `cnt`-1.
- Simultaneous release and timeout: single exit; no difference in outcome.
- `owner` and `q` keep their values after exit until the next grant.
- No grant is ever issued in the same cycle as an exit. At least one IDLE cycle separates consecutive grants.
- Wrap-around: `ptr`=N-1 scans from index 0. A requester that is the sole requester is regranted after one IDLE cycle.

## Timing
- Grant latency: `req` seen in IDLE at edge k, so `gnt`/`q`/`busy` are valid after edge k. One cycle from request to grant when idle.
- With a continuously asserted owner request, `gnt` stays high exactly HOLD_CYC cycles, then is low for at least 1 cycle.
- Early release: owner drops `req` in cycle j, so `gnt` falls after edge j.
- Fairness bound: a continuously requesting requester waits at most (N-1)·(HOLD_CYC+1) cycles in IDLE/HOLD before its grant edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use N=4, W=8, HOLD_CYC=3.
- Reset: `rst`=0 for 2 edges with `req`=4'b1111 -> `q`=0, `gnt`=0, `busy`=0, `owner`=0 throughout; first grant after release of `rst` goes to requester 0.
- Single request: `req`=4'b0100, lane2=8'hA5 held high -> next edge `gnt`=4'b0100, `q`=A5; `gnt` high 3 cycles, low 1 cycle, then regranted to 2.
- Round robin: `req`=4'b1111, lanes 11/22/33/44 held -> grant order 0,1,2,3,0 with `q`=11,22,33,44,11; each grant 3 cycles, 1-cycle gap.
- Early release: requester 1 granted, drops `req` in the 1st HOLD cycle -> `gnt`=0 after that edge; `q` keeps lane1 value; `owner`=1.
- HOLD isolation: during HOLD, the owner's lane changes to 8'hFF and requester 3 raises `req` -> `q` unchanged; 3 is granted only after the IDLE gap.
- Reset mid-HOLD: drop `rst` in the 2nd HOLD cycle -> next edge all outputs at reset values; `ptr` restarts so requester 0 wins next.
